// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle RV32M execute unit.
// Multiplies take 2 cycles. Divides use a radix-2 restoring loop of DIV_CYCLES
// iterations. Divide-by-zero and signed overflow are resolved on the short
// (multiply) path.
//
// Handshake: start is sampled only in IDLE. It is accepted when is_md=1 and
// flush=0; busy stays high from the accept edge until the cycle after done.
// done pulses for exactly one cycle, and result is valid in that cycle.
// result then holds its value until the next done.
module mul_div_unit #(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      ALU_sel,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            is_md,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_result;

  // Request decode, taken straight from the live inputs while IDLE.
  logic            w_accept;
  logic            w_signed_div;
  logic            w_special;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;

  assign is_md        = (ALU_sel[4:3] == 2'b01);
  assign w_accept     = (r_state == S_IDLE) && start && is_md && !flush;
  assign w_signed_div = is_md && ALU_sel[2] && !ALU_sel[0];
  assign w_special    = ALU_sel[2] &&
                        ((operand2 == '0) ||
                         (w_signed_div && (operand1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                          (operand2 == '1)));
  assign w_abs1       = (w_signed_div && operand1[XLEN-1]) ? (~operand1 + 1'b1) : operand1;
  assign w_abs2       = (w_signed_div && operand2[XLEN-1]) ? (~operand2 + 1'b1) : operand2;

  // One restoring-division step: shift in the next dividend bit, then subtract.
  // Whenever the subtract is taken, the true difference is below the divisor,
  // so the low XLEN bits of the modular subtraction are exact.
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_sub;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_quo_nx;
  logic            w_neg_q;
  logic            w_neg_r;
  logic [XLEN-1:0] w_div_res;

  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dvs});
  assign w_sub     = w_shift[XLEN-1:0] - r_dvs;
  assign w_rem_nx  = w_ge ? w_sub : w_shift[XLEN-1:0];
  assign w_quo_nx  = {r_quo[XLEN-2:0], w_ge};
  assign w_neg_q   = !r_op[0] && (r_a[XLEN-1] ^ r_b[XLEN-1]);
  assign w_neg_r   = !r_op[0] && r_a[XLEN-1];
  assign w_div_res = r_op[1] ? (w_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx)
                             : (w_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx);

  // Short path: XLEN+1-bit sign/zero-extended multiply, or a div/rem special case.
  logic [XLEN:0]     w_a_ext;
  logic [XLEN:0]     w_b_ext;
  logic [2*XLEN-1:0] w_a_wide;
  logic [2*XLEN-1:0] w_b_wide;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;
  logic [XLEN-1:0]   w_spc_res;
  logic [XLEN-1:0]   w_short_res;

  assign w_a_ext     = {((r_op == 3'b001) || (r_op == 3'b010)) && r_a[XLEN-1], r_a};
  assign w_b_ext     = {(r_op == 3'b001) && r_b[XLEN-1], r_b};
  assign w_a_wide    = {{(XLEN-1){w_a_ext[XLEN]}}, w_a_ext};
  assign w_b_wide    = {{(XLEN-1){w_b_ext[XLEN]}}, w_b_ext};
  assign w_prod      = w_a_wide * w_b_wide;
  assign w_mul_res   = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  // Divide by zero: quotient all ones, remainder is the dividend.
  // Signed overflow: quotient is the dividend (most negative), remainder is zero.
  assign w_spc_res   = (r_b == '0) ? (r_op[1] ? r_a : '1) : (r_op[1] ? '0 : r_a);
  assign w_short_res = r_op[2] ? w_spc_res : w_mul_res;

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic: flush aborts MUL/DIV, but never cuts a DONE short.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (!ALU_sel[2] || w_special) ? S_MUL : S_DIV;
      S_MUL:  w_next = flush ? S_IDLE : S_DONE;
      S_DIV:  if (flush) w_next = S_IDLE;
              else if (r_cnt == CW'(DIV_CYCLES-1)) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture at accept, iterate in DIV, and write result on completion.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op  <= ALU_sel[2:0];
          r_a   <= operand1;
          r_b   <= operand2;
          r_rem <= '0;
          r_quo <= w_abs1;
          r_dvs <= w_abs2;
          r_cnt <= '0;
        end
        S_MUL: if (!flush) r_result <= w_short_res;
        S_DIV: if (!flush) begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(DIV_CYCLES-1)) r_result <= w_div_res;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign result    = r_result;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed vectors with hand-computed results.
// The driver pushes the expected result and its due cycle; the negedge
// monitor pops and compares them whenever done is high.
module tb_mul_div_unit;

  localparam logic [4:0] OP_MUL    = 5'b01000;
  localparam logic [4:0] OP_MULH   = 5'b01001;
  localparam logic [4:0] OP_MULHSU = 5'b01010;
  localparam logic [4:0] OP_MULHU  = 5'b01011;
  localparam logic [4:0] OP_DIV    = 5'b01100;
  localparam logic [4:0] OP_DIVU   = 5'b01101;
  localparam logic [4:0] OP_REM    = 5'b01110;
  localparam logic [4:0] OP_REMU   = 5'b01111;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        start;
  logic        flush;
  logic [4:0]  ALU_sel;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        is_md;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int ncyc   = 0;

  logic [31:0] exp_q[$];
  int          due_q[$];
  string       name_q[$];

  mul_div_unit #(.XLEN(32), .DIV_CYCLES(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .flush(flush),
    .ALU_sel(ALU_sel), .operand1(operand1), .operand2(operand2),
    .is_md(is_md), .busy(busy), .done(done), .result(result),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: count negedges; compare whenever done is high.
  always @(negedge CLK) begin
    ncyc++;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 (result %h), expected no done", result);
      end else begin
        logic [31:0] e;
        int          d;
        string       nm;
        e  = exp_q.pop_front();
        d  = due_q.pop_front();
        nm = name_q.pop_front();
        check({nm, "_result"}, result, e);
        check({nm, "_latency"}, 32'(ncyc), 32'(d));
      end
    end
  end

  // Driver tasks
  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge CLK);
    if (busy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_idle: got busy=1, expected 0 within 200 cycles");
    end
  endtask

  task automatic issue(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input bit hold);
    wait_idle();
    start    = 1'b1;
    ALU_sel  = op;
    operand1 = a;
    operand2 = b;
    @(posedge CLK);
    #1;
    check({name, "_accept"}, {31'b0, busy}, 32'd1);
    exp_q.push_back(exp);
    due_q.push_back(ncyc + lat);
    name_q.push_back(name);
    if (!hold) begin
      start   = 1'b0;
      ALU_sel = 5'b00000;
    end
  endtask

  task automatic drop_pending();
    exp_q.delete();
    due_q.delete();
    name_q.delete();
  endtask

  // Stimulus
  initial begin
    RESET_N  = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    ALU_sel  = 5'b00000;
    operand1 = '0;
    operand2 = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy",  {31'b0, busy}, 32'd0);
    check("rst_done",  {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // is_md decode
    ALU_sel = OP_MUL;   #1 check("is_md_mul",   {31'b0, is_md}, 32'd1);
    ALU_sel = OP_REMU;  #1 check("is_md_remu",  {31'b0, is_md}, 32'd1);
    ALU_sel = 5'b00000; #1 check("is_md_zero",  {31'b0, is_md}, 32'd0);
    ALU_sel = 5'b11000; #1 check("is_md_11000", {31'b0, is_md}, 32'd0);
    ALU_sel = 5'b00111; #1 check("is_md_00111", {31'b0, is_md}, 32'd0);

    // Non-M code with start held high: never accepted
    @(negedge CLK);
    ALU_sel = 5'b00000;
    start   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("nonm_busy", {31'b0, busy}, 32'd0);
    end
    // flush in IDLE blocks acceptance
    ALU_sel = OP_MUL;
    flush   = 1'b1;
    @(posedge CLK);
    #1 check("idle_flush_busy", {31'b0, busy}, 32'd0);
    start   = 1'b0;
    flush   = 1'b0;
    ALU_sel = 5'b00000;

    // Multiplies
    issue("mul",      OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 2, 0);
    issue("mulh",     OP_MULH,   32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 2, 0);
    issue("mulhu",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, 0);
    issue("mulhsu",   OP_MULHSU, 32'h00000002, 32'h80000000, 32'h00000001, 2, 0);
    issue("mulh_neg", OP_MULH,   32'h00000002, 32'h80000000, 32'hFFFFFFFF, 2, 0);

    // Divides
    issue("div_m20_3",   OP_DIV,  32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 33, 0);
    issue("rem_m20_3",   OP_REM,  32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 33, 0);
    issue("div_20_m3",   OP_DIV,  32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA, 33, 0);
    issue("rem_20_m3",   OP_REM,  32'd20, 32'hFFFFFFFD, 32'h00000002, 33, 0);
    issue("divu_100_7",  OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
    issue("remu_100_7",  OP_REMU, 32'd100, 32'd7, 32'd2, 33, 0);
    issue("divu_big_3",  OP_DIVU, 32'hFFFFFFEC, 32'd3, 32'h5555554E, 33, 0);

    // Special cases on the short path
    issue("divu_by0",  OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 2, 0);
    issue("div_by0",   OP_DIV,  32'd5, 32'd0, 32'hFFFFFFFF, 2, 0);
    issue("rem_by0",   OP_REM,  32'd5, 32'd0, 32'd5, 2, 0);
    issue("remu_by0",  OP_REMU, 32'd5, 32'd0, 32'd5, 2, 0);
    issue("div_ovf",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, 0);
    issue("rem_ovf",   OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2, 0);

    // Handshake: start held high, inputs changed mid-operation
    issue("hs_div", OP_DIV, 32'd100, 32'd7, 32'd14, 33, 1);
    repeat (4) @(negedge CLK);
    operand1 = 32'd1000;
    operand2 = 32'd3;
    ALU_sel  = OP_MUL;
    check("hs_busy_c5", {31'b0, busy}, 32'd1);
    repeat (15) @(negedge CLK);
    check("hs_busy_c20", {31'b0, busy}, 32'd1);
    check("hs_state_div", {30'b0, dbg_state}, 32'd2);
    start   = 1'b0;
    ALU_sel = 5'b00000;

    // Flush mid-divide: no done, result keeps the handshake value
    issue("fl_div", OP_DIV, 32'd1000, 32'd3, 32'd333, 33, 0);
    repeat (14) @(negedge CLK);
    flush = 1'b1;
    @(posedge CLK);
    #1;
    flush = 1'b0;
    drop_pending();
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_result_hold", result, 32'd14);
    issue("mul_after_flush", OP_MUL, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 2, 0);
    wait_idle();

    // Reset mid-divide
    issue("rst_div", OP_DIV, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 33, 0);
    repeat (10) @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    drop_pending();
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (40) @(negedge CLK);
    check("postrst_busy", {31'b0, busy}, 32'd0);

    // Drain: every expected result must have been seen
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge CLK);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
